// File: rtl/counter.sv
// Up-counter with a configurable terminal count and reset value.
// The count wraps to zero after MAX_VALUE and out is taken straight from the count register.
module counter #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;

  // Count register: async reset, advance on enable, wrap past the terminal count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= RESET_VALUE;
    end else if (enable) begin
      // >= rather than == so an out-of-range value recovers to zero
      if (count_r >= MAX_VALUE) begin
        count_r <= ZERO;
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign out = count_r;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default instance plus a MAX_VALUE=9 / RESET_VALUE=3 instance.
module tb_counter;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] out_a;
  logic [3:0] out_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    string      name;
  } vec_t;

  vec_t vecs[$];

  counter dut_a (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .out    (out_a)
  );

  counter #(
    .WIDTH       (4),
    .MAX_VALUE   (4'd9),
    .RESET_VALUE (4'd3)
  ) dut_b (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .out    (out_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic rst, input logic en, input int ea, input int eb, input string name);
    vec_t v;
    v.rst   = rst;
    v.en    = en;
    v.exp_a = 4'(ea);
    v.exp_b = 4'(eb);
    v.name  = name;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Hold for 3 edges after reset
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 0, 3, "hold");
    // Count and wrap over 20 edges
    for (int i = 1; i <= 20; i++) push(1'b1, 1'b1, i % 16, (3 + i) % 10, "count");
    // Reset coinciding with enable
    push(1'b0, 1'b1, 0, 3, "reset_pri");
    // Pause: 5 enabled, 3 held, 2 enabled
    for (int i = 1; i <= 5; i++) push(1'b1, 1'b1, i, 3 + i, "pause_run");
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 5, 8, "pause_hold");
    push(1'b1, 1'b1, 6, 9, "pause_resume");
    push(1'b1, 1'b1, 7, 0, "pause_resume");
    // Advance to 9 for the mid-count reset
    push(1'b1, 1'b1, 8, 1, "to_nine");
    push(1'b1, 1'b1, 9, 2, "to_nine");

    reset  = 1'b1;
    enable = 1'b0;

    // Async reset between edges
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_a", out_a, 4'd0);
    check("async_reset_b", out_b, 4'd3);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check("reset_hold_a", out_a, 4'd0);
      check("reset_hold_b", out_b, 4'd3);
    end

    foreach (vecs[i]) begin
      @(negedge clock);
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      @(posedge clock);
      #1;
      check({vecs[i].name, "_a"}, out_a, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, out_b, vecs[i].exp_b);
    end

    // Mid-count reset at out_a==9, then release with enable high
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;
    #1;
    check("midreset_a", out_a, 4'd0);
    check("midreset_b", out_b, 4'd3);
    @(posedge clock);
    #1;
    check("midreset_edge_a", out_a, 4'd0);
    check("midreset_edge_b", out_b, 4'd3);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("release_a", out_a, 4'd1);
    check("release_b", out_b, 4'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
